uart_rx_cfg: RTL and testbench

Parametrised second-generation UART receiver. It converts an asynchronous serial line into DATA_W-bit parallel words with a registered one-cycle valid strobe and explicit per-frame error flags. The oversampling ratio and frame format are set at runtime and latched at each start bit. Each bit is decided by a 3-sample majority vote. The block sits on the oversampled UART clock domain and feeds the RX data synchroniser / register-file path.

---
 rtl/uart_rx_cfg.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver with 3-sample majority bit voting.
// Optional break detection (BREAK pulse plus BRK_WAIT state) is built when UART_RX_BREAK_EN is defined.
module uart_rx_cfg #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              RX_IN,
  input  logic [5:0]        Prescale,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic              STOP2,
  output logic [DATA_W-1:0] P_DATA,
  output logic              DATA_Valid,
  output logic              PAR_ERR,
  output logic              STP_ERR,
  output logic              BUSY,
  output logic              BREAK
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] DATA     = 3'd2;
  localparam logic [2:0] PARITY   = 3'd3;
  localparam logic [2:0] STOP     = 3'd4;
`ifdef UART_RX_BREAK_EN
  localparam logic [2:0] BRK_WAIT = 3'd5;
`endif
  localparam logic [3:0] LAST_DATA = 4'(DATA_W);

  function automatic logic [5:0] norm_prescale(input logic [5:0] ps);
    case (ps)
      6'd8, 6'd16, 6'd32: return ps;
      default:            return 6'd16;
    endcase
  endfunction

  function automatic logic odd_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic              rx_meta_r, rx_sync_r;
  logic [2:0]        state_r, state_s;
  logic [4:0]        edge_cnt_r, edge_cnt_s;
  logic [3:0]        bit_cnt_r, bit_cnt_s;
  logic [5:0]        p_r, p_s;
  logic              par_en_r, par_en_s;
  logic              par_typ_r, par_typ_s;
  logic              stop2_r, stop2_s;
  logic [1:0]        samp_r, samp_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic              par_fail_r, par_fail_s;
  logic              stp_fail_r, stp_fail_s;
  logic [DATA_W-1:0] p_data_r, p_data_s;
  logic              data_valid_r, data_valid_s;
  logic              par_err_r, par_err_s;
  logic              stp_err_r, stp_err_s;
  logic              busy_r, busy_s;
`ifdef UART_RX_BREAK_EN
  logic              any_one_r, any_one_s;
  logic              break_r, break_s;
`endif

  logic [4:0] mid_s, mid_m1_s, mid_p1_s;
  logic [3:0] last_idx_s;
  logic       frame_act_s, bit_end_s, vote_now_s, vote_s, stop_fail_now_s;

  assign mid_s      = p_r[5:1];
  assign mid_m1_s   = mid_s - 5'd1;
  assign mid_p1_s   = mid_s + 5'd1;
  assign last_idx_s = LAST_DATA + 4'd1 + {3'd0, par_en_r} + {3'd0, stop2_r};
  assign frame_act_s = (state_r == START) || (state_r == DATA) ||
                       (state_r == PARITY) || (state_r == STOP);
  assign bit_end_s  = ({1'b0, edge_cnt_r} == (p_r - 6'd1));
  assign vote_now_s = (edge_cnt_r == mid_p1_s);
  assign vote_s     = maj3(samp_r[0], samp_r[1], rx_sync_r);
  assign stop_fail_now_s = stp_fail_r | ~vote_s;

  // Two-flop synchroniser for the raw serial line (resets to idle-high).
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= RX_IN;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Next-state logic: bit timing, sampling, voting and frame-end output decode.
  always_comb begin
    state_s      = state_r;
    edge_cnt_s   = edge_cnt_r;
    bit_cnt_s    = bit_cnt_r;
    p_s          = p_r;
    par_en_s     = par_en_r;
    par_typ_s    = par_typ_r;
    stop2_s      = stop2_r;
    samp_s       = samp_r;
    shift_s      = shift_r;
    par_fail_s   = par_fail_r;
    stp_fail_s   = stp_fail_r;
    p_data_s     = p_data_r;
    data_valid_s = 1'b0;
    par_err_s    = 1'b0;
    stp_err_s    = 1'b0;
`ifdef UART_RX_BREAK_EN
    any_one_s    = any_one_r;
    break_s      = 1'b0;
`endif

    if (frame_act_s) begin
      if (bit_end_s) begin
        edge_cnt_s = 5'd0;
        bit_cnt_s  = bit_cnt_r + 4'd1;
      end else begin
        edge_cnt_s = edge_cnt_r + 5'd1;
      end
      if (edge_cnt_r == mid_m1_s) begin
        samp_s[0] = rx_sync_r;
      end else if (edge_cnt_r == mid_s) begin
        samp_s[1] = rx_sync_r;
      end else begin
        samp_s = samp_r;
      end
    end else begin
      samp_s = samp_r;
    end

    case (state_r)
      IDLE: begin
        if (!rx_sync_r) begin
          state_s    = START;
          p_s        = norm_prescale(Prescale);
          par_en_s   = PAR_EN;
          par_typ_s  = PAR_TYP;
          stop2_s    = STOP2;
          edge_cnt_s = 5'd0;
          bit_cnt_s  = 4'd0;
          par_fail_s = 1'b0;
          stp_fail_s = 1'b0;
`ifdef UART_RX_BREAK_EN
          any_one_s  = 1'b0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (vote_now_s && vote_s) begin
          state_s = IDLE;
        end else if (bit_end_s) begin
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (vote_now_s) begin
          shift_s = {vote_s, shift_r[DATA_W-1:1]};
`ifdef UART_RX_BREAK_EN
          any_one_s = any_one_r | vote_s;
`endif
        end else begin
          shift_s = shift_r;
        end
        if (bit_end_s && (bit_cnt_r == LAST_DATA)) begin
          state_s = par_en_r ? PARITY : STOP;
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (vote_now_s) begin
          par_fail_s = par_fail_r | ((odd_parity(shift_r) ^ vote_s) != par_typ_r);
`ifdef UART_RX_BREAK_EN
          any_one_s  = any_one_r | vote_s;
`endif
        end else begin
          par_fail_s = par_fail_r;
        end
        state_s = bit_end_s ? STOP : PARITY;
      end
      STOP: begin
        if (vote_now_s) begin
          stp_fail_s = stop_fail_now_s;
          if (bit_cnt_r == last_idx_s) begin
            // The trailing half of the last stop bit is skipped so the next start edge is never missed.
            if (!stop_fail_now_s && !par_fail_r) begin
              data_valid_s = 1'b1;
              p_data_s     = shift_r;
            end else begin
              par_err_s = par_fail_r;
              stp_err_s = stop_fail_now_s;
            end
`ifdef UART_RX_BREAK_EN
            if (stop_fail_now_s && !any_one_r) begin
              break_s    = 1'b1;
              state_s    = BRK_WAIT;
              edge_cnt_s = 5'd0;
            end else begin
              state_s = IDLE;
            end
`else
            state_s = IDLE;
`endif
          end else begin
            state_s = STOP;
          end
        end else begin
          state_s = STOP;
        end
      end
`ifdef UART_RX_BREAK_EN
      BRK_WAIT: begin
        if (rx_sync_r) begin
          if ({1'b0, edge_cnt_r} == (p_r - 6'd1)) begin
            state_s = IDLE;
          end else begin
            edge_cnt_s = edge_cnt_r + 5'd1;
          end
        end else begin
          edge_cnt_s = 5'd0;
        end
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // Frame state and registered outputs.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_r      <= IDLE;
      edge_cnt_r   <= 5'd0;
      bit_cnt_r    <= 4'd0;
      p_r          <= 6'd16;
      par_en_r     <= 1'b0;
      par_typ_r    <= 1'b0;
      stop2_r      <= 1'b0;
      samp_r       <= 2'b11;
      shift_r      <= '0;
      par_fail_r   <= 1'b0;
      stp_fail_r   <= 1'b0;
      p_data_r     <= '0;
      data_valid_r <= 1'b0;
      par_err_r    <= 1'b0;
      stp_err_r    <= 1'b0;
      busy_r       <= 1'b0;
`ifdef UART_RX_BREAK_EN
      any_one_r    <= 1'b0;
      break_r      <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      edge_cnt_r   <= edge_cnt_s;
      bit_cnt_r    <= bit_cnt_s;
      p_r          <= p_s;
      par_en_r     <= par_en_s;
      par_typ_r    <= par_typ_s;
      stop2_r      <= stop2_s;
      samp_r       <= samp_s;
      shift_r      <= shift_s;
      par_fail_r   <= par_fail_s;
      stp_fail_r   <= stp_fail_s;
      p_data_r     <= p_data_s;
      data_valid_r <= data_valid_s;
      par_err_r    <= par_err_s;
      stp_err_r    <= stp_err_s;
      busy_r       <= busy_s;
`ifdef UART_RX_BREAK_EN
      any_one_r    <= any_one_s;
      break_r      <= break_s;
`endif
    end
  end

  assign P_DATA     = p_data_r;
  assign DATA_Valid = data_valid_r;
  assign PAR_ERR    = par_err_r;
  assign STP_ERR    = stp_err_r;
  assign BUSY       = busy_r;
`ifdef UART_RX_BREAK_EN
  assign BREAK      = break_r;
`else
  assign BREAK      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8-bit instance and a 5-bit instance on separate serial lines.
module tb_uart_rx_cfg;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic       rx8, rx5;
  logic [5:0] Prescale;
  logic       PAR_EN, PAR_TYP, STOP2;
  logic [7:0] pd8;
  logic [4:0] pd5;
  logic       dv8, perr8, serr8, busy8, brk8;
  logic       dv5, perr5, serr5, busy5, brk5;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int l0, l0a;

  int         v8_cyc[$];
  logic [7:0] v8_dat[$];
  int         v5_cyc[$];
  logic [4:0] v5_dat[$];
  int par8, stp8, brk8_n, err5, last_stp8, last_brk8, busy_fall8;
  logic busy_prev8 = 1'b0;

  always #5 CLK = ~CLK;

  uart_rx_cfg #(.DATA_W(8)) dut8 (
    .CLK(CLK), .RST_n(RST_n), .RX_IN(rx8), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .STOP2(STOP2), .P_DATA(pd8), .DATA_Valid(dv8), .PAR_ERR(perr8),
    .STP_ERR(serr8), .BUSY(busy8), .BREAK(brk8));

  uart_rx_cfg #(.DATA_W(5)) dut5 (
    .CLK(CLK), .RST_n(RST_n), .RX_IN(rx5), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .STOP2(STOP2), .P_DATA(pd5), .DATA_Valid(dv5), .PAR_ERR(perr5),
    .STP_ERR(serr5), .BUSY(busy5), .BREAK(brk5));

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (dv8) begin v8_cyc.push_back(cyc); v8_dat.push_back(pd8); end
    if (perr8) par8++;
    if (serr8) begin stp8++; last_stp8 = cyc; end
    if (brk8) begin brk8_n++; last_brk8 = cyc; end
    if (busy_prev8 && !busy8) busy_fall8 = cyc;
    busy_prev8 = busy8;
    if (dv5) begin v5_cyc.push_back(cyc); v5_dat.push_back(pd5); end
    if (perr5 || serr5 || brk5) err5++;
  end

  task automatic clear_mon();
    v8_cyc.delete(); v8_dat.delete(); v5_cyc.delete(); v5_dat.delete();
    par8 = 0; stp8 = 0; brk8_n = 0; err5 = 0;
    last_stp8 = -1; last_brk8 = -1; busy_fall8 = -1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      rx8 = 1'b1; rx5 = 1'b1;
    end
  endtask

  // Drive nb bits LSB-first, p cycles each; the line cycle with index glitch is inverted.
  task automatic drive_bits(input logic [15:0] bits, input int nb, input int p,
                            input int glitch, input bit sel5);
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < p; j++) begin
        @(posedge CLK); #1;
        if (i == 0 && j == 0) l0 = cyc;
        if (sel5) rx5 = bits[i] ^ ((i * p + j) == glitch);
        else      rx8 = bits[i] ^ ((i * p + j) == glitch);
      end
    end
  endtask

  task automatic test_reset();
    RST_n = 1'b0; rx8 = 1'b1; rx5 = 1'b1;
    Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    clear_mon();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    if (pd8 !== 8'h00) begin $display("FAIL reset_p_data: got %h want 00", pd8); n_err++; end n_vec++;
    if (pd5 !== 5'h00) begin $display("FAIL reset_p_data5: got %h want 00", pd5); n_err++; end n_vec++;
    if ({dv8, perr8, serr8, busy8, brk8} !== 5'b0) begin
      $display("FAIL reset_flags: got %b want 00000", {dv8, perr8, serr8, busy8, brk8}); n_err++;
    end n_vec++;
    @(posedge CLK); #1 RST_n = 1'b1;
    idle(10);
    if ({dv8, perr8, serr8, busy8, brk8} !== 5'b0) begin
      $display("FAIL idle_flags: got %b want 00000", {dv8, perr8, serr8, busy8, brk8}); n_err++;
    end n_vec++;
  endtask

  task automatic test_basic();
    Prescale = 6'd16; PAR_EN = 1'b0; STOP2 = 1'b0;
    clear_mon();
    drive_bits({6'd0, 1'b1, 8'hA5, 1'b0}, 10, 16, -1, 1'b0);
    idle(40);
    if (v8_cyc.size() !== 1) begin
      $display("FAIL basic_count: got %0d want 1", v8_cyc.size()); n_err++;
    end else begin
      if (v8_dat[0] !== 8'hA5) begin $display("FAIL basic_data: got %h want a5", v8_dat[0]); n_err++; end n_vec++;
      if (v8_cyc[0] !== l0 + 157) begin $display("FAIL basic_time: got %0d want %0d", v8_cyc[0], l0 + 157); n_err++; end n_vec++;
    end n_vec++;
    if (busy_fall8 !== l0 + 157) begin $display("FAIL basic_busy_fall: got %0d want %0d", busy_fall8, l0 + 157); n_err++; end n_vec++;
    if (par8 + stp8 !== 0) begin $display("FAIL basic_errs: got %0d want 0", par8 + stp8); n_err++; end n_vec++;
    if (pd8 !== 8'hA5) begin $display("FAIL basic_hold: got %h want a5", pd8); n_err++; end n_vec++;
  endtask

  task automatic test_parity();
    Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b0;
    clear_mon();
    drive_bits({5'd0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11, 8, -1, 1'b0);
    idle(30);
    if (v8_cyc.size() !== 1) begin
      $display("FAIL par_ok_count: got %0d want 1", v8_cyc.size()); n_err++;
    end else begin
      if (v8_dat[0] !== 8'h3C) begin $display("FAIL par_ok_data: got %h want 3c", v8_dat[0]); n_err++; end n_vec++;
      if (v8_cyc[0] !== l0 + 89) begin $display("FAIL par_ok_time: got %0d want %0d", v8_cyc[0], l0 + 89); n_err++; end n_vec++;
    end n_vec++;
    if (par8 !== 0) begin $display("FAIL par_ok_perr: got %0d want 0", par8); n_err++; end n_vec++;
    clear_mon();
    drive_bits({5'd0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, 8, -1, 1'b0);
    idle(30);
    if (par8 !== 1) begin $display("FAIL par_bad_perr: got %0d want 1", par8); n_err++; end n_vec++;
    if (v8_cyc.size() !== 0) begin $display("FAIL par_bad_valid: got %0d want 0", v8_cyc.size()); n_err++; end n_vec++;
    if (stp8 !== 0) begin $display("FAIL par_bad_stp: got %0d want 0", stp8); n_err++; end n_vec++;
    if (pd8 !== 8'h3C) begin $display("FAIL par_bad_hold: got %h want 3c", pd8); n_err++; end n_vec++;
  endtask

  task automatic test_stop2();
    Prescale = 6'd32; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b1;
    clear_mon();
    drive_bits({5'd0, 1'b0, 1'b1, 8'h5E, 1'b0}, 11, 32, -1, 1'b0);
    drive_bits({5'd0, 1'b1, 1'b1, 8'h81, 1'b0}, 11, 32, -1, 1'b0);
    idle(60);
    if (stp8 !== 1) begin $display("FAIL stop2_stp: got %0d want 1", stp8); n_err++; end n_vec++;
    if (par8 + brk8_n !== 0) begin $display("FAIL stop2_other: got %0d want 0", par8 + brk8_n); n_err++; end n_vec++;
    if (v8_cyc.size() !== 1) begin
      $display("FAIL stop2_count: got %0d want 1", v8_cyc.size()); n_err++;
    end else begin
      if (v8_dat[0] !== 8'h81) begin $display("FAIL stop2_data: got %h want 81", v8_dat[0]); n_err++; end n_vec++;
    end n_vec++;
  endtask

  task automatic test_glitch();
    Prescale = 6'd16; PAR_EN = 1'b0; STOP2 = 1'b0;
    clear_mon();
    drive_bits(16'h0000, 3, 1, -1, 1'b0);
    idle(40);
    if (v8_cyc.size() + par8 + stp8 + brk8_n !== 0) begin
      $display("FAIL glitch_pulses: got %0d want 0", v8_cyc.size() + par8 + stp8 + brk8_n); n_err++;
    end n_vec++;
    if (busy_fall8 !== l0 + 13) begin $display("FAIL glitch_busy_fall: got %0d want %0d", busy_fall8, l0 + 13); n_err++; end n_vec++;
    clear_mon();
    drive_bits({6'd0, 1'b1, 8'h55, 1'b0}, 10, 16, 73, 1'b0);
    idle(40);
    if (v8_cyc.size() !== 1) begin
      $display("FAIL vote_count: got %0d want 1", v8_cyc.size()); n_err++;
    end else begin
      if (v8_dat[0] !== 8'h55) begin $display("FAIL vote_data: got %h want 55", v8_dat[0]); n_err++; end n_vec++;
    end n_vec++;
  endtask

  task automatic test_back_to_back();
    Prescale = 6'd20; PAR_EN = 1'b0; STOP2 = 1'b0;
    clear_mon();
    drive_bits({9'd0, 1'b1, 5'h15, 1'b0}, 7, 16, -1, 1'b1);
    l0a = l0;
    drive_bits({9'd0, 1'b1, 5'h0A, 1'b0}, 7, 16, -1, 1'b1);
    idle(40);
    if (v5_cyc.size() !== 2) begin
      $display("FAIL b2b_count: got %0d want 2", v5_cyc.size()); n_err++;
    end else begin
      if (v5_dat[0] !== 5'h15) begin $display("FAIL b2b_data0: got %h want 15", v5_dat[0]); n_err++; end n_vec++;
      if (v5_dat[1] !== 5'h0A) begin $display("FAIL b2b_data1: got %h want 0a", v5_dat[1]); n_err++; end n_vec++;
      if (v5_cyc[0] !== l0a + 109) begin $display("FAIL b2b_time0: got %0d want %0d", v5_cyc[0], l0a + 109); n_err++; end n_vec++;
      if (v5_cyc[1] - v5_cyc[0] !== 112) begin $display("FAIL b2b_gap: got %0d want 112", v5_cyc[1] - v5_cyc[0]); n_err++; end n_vec++;
    end n_vec++;
    if (err5 !== 0) begin $display("FAIL b2b_errs: got %0d want 0", err5); n_err++; end n_vec++;
  endtask

  task automatic test_reset_mid();
    Prescale = 6'd16; PAR_EN = 1'b0; STOP2 = 1'b0;
    drive_bits({6'd0, 1'b1, 8'h5A, 1'b0}, 4, 16, -1, 1'b0);
    @(posedge CLK); #1;
    RST_n = 1'b0; rx8 = 1'b1;
    #1;
    if (pd8 !== 8'h00) begin $display("FAIL rstmid_p_data: got %h want 00", pd8); n_err++; end n_vec++;
    if (busy8 !== 1'b0) begin $display("FAIL rstmid_busy: got %b want 0", busy8); n_err++; end n_vec++;
    repeat (3) @(posedge CLK);
    #1 RST_n = 1'b1;
    idle(20);
    clear_mon();
    drive_bits({6'd0, 1'b1, 8'h6B, 1'b0}, 10, 16, -1, 1'b0);
    idle(40);
    if (v8_cyc.size() !== 1) begin
      $display("FAIL rstmid_count: got %0d want 1", v8_cyc.size()); n_err++;
    end else begin
      if (v8_dat[0] !== 8'h6B) begin $display("FAIL rstmid_data: got %h want 6b", v8_dat[0]); n_err++; end n_vec++;
      if (v8_cyc[0] !== l0 + 157) begin $display("FAIL rstmid_time: got %0d want %0d", v8_cyc[0], l0 + 157); n_err++; end n_vec++;
    end n_vec++;
  endtask

  task automatic test_held_low();
    Prescale = 6'd16; PAR_EN = 1'b0; STOP2 = 1'b0;
    clear_mon();
`ifdef UART_RX_BREAK_EN
    drive_bits(16'h0000, 1, 480, -1, 1'b0);
    idle(60);
    if (brk8_n !== 1) begin $display("FAIL brk_count: got %0d want 1", brk8_n); n_err++; end n_vec++;
    if (stp8 !== 1) begin $display("FAIL brk_stp: got %0d want 1", stp8); n_err++; end n_vec++;
    if (last_brk8 !== l0 + 157) begin $display("FAIL brk_time: got %0d want %0d", last_brk8, l0 + 157); n_err++; end n_vec++;
    if (last_stp8 !== l0 + 157) begin $display("FAIL brk_stp_time: got %0d want %0d", last_stp8, l0 + 157); n_err++; end n_vec++;
    if (busy_fall8 !== l0 + 498) begin $display("FAIL brk_busy_fall: got %0d want %0d", busy_fall8, l0 + 498); n_err++; end n_vec++;
`else
    drive_bits(16'h0000, 1, 310, -1, 1'b0);
    idle(200);
    if (stp8 !== 2) begin $display("FAIL held_stp: got %0d want 2", stp8); n_err++; end n_vec++;
    if (brk8_n !== 0) begin $display("FAIL held_brk: got %0d want 0", brk8_n); n_err++; end n_vec++;
    if (last_stp8 !== l0 + 312) begin $display("FAIL held_stp_time: got %0d want %0d", last_stp8, l0 + 312); n_err++; end n_vec++;
    if (busy_fall8 !== l0 + 312) begin $display("FAIL held_busy_fall: got %0d want %0d", busy_fall8, l0 + 312); n_err++; end n_vec++;
`endif
    if (v8_cyc.size() !== 0) begin $display("FAIL held_valid: got %0d want 0", v8_cyc.size()); n_err++; end n_vec++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_held_low();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
